// File: rtl/apb_timer_arbiter.sv
// Two-master round-robin APB arbiter in front of the timer wrapper slave port.
// Each granted transfer is replayed as one setup/access pair, with an optional access timeout.
module apb_timer_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_psel,
    input  logic          m0_penable,
    input  logic          m0_pwrite,
    input  logic [AW-1:0] m0_paddr,
    input  logic [31:0]   m0_pwdata,
    output logic [31:0]   m0_prdata,
    output logic          m0_pready,
    output logic          m0_pslverr,
    input  logic          m1_psel,
    input  logic          m1_penable,
    input  logic          m1_pwrite,
    input  logic [AW-1:0] m1_paddr,
    input  logic [31:0]   m1_pwdata,
    output logic [31:0]   m1_prdata,
    output logic          m1_pready,
    output logic          m1_pslverr,
    output logic          s_psel,
    output logic          s_penable,
    output logic          s_pwrite,
    output logic [AW-1:0] s_paddr,
    output logic [31:0]   s_pwdata,
    input  logic [31:0]   s_prdata,
    input  logic          s_pready,
    input  logic          s_pslverr,
    output logic [1:0]    grant_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic timeoutHit;
    logic done;
    logic masterDone;
    logic winner;
    logic active;
    logic unusedPenable;

    // Masters are requesting as soon as psel rises; their penable carries no extra information here.
    assign unusedPenable = m0_penable ^ m1_penable;

    assign active     = (state_q != IDLE);
    assign timeoutHit = (TIMEOUT != 0) && (state_q == ACCESS) && !s_pready && (cnt_q == CNT_LAST);
    assign done       = (state_q == ACCESS) && (s_pready || timeoutHit);
    assign masterDone = done && !rst_i;
    assign winner     = (m0_psel && m1_psel) ? ~last_q : m1_psel;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (m0_psel || m1_psel) begin
                    state_d  = SETUP;
                    grant_d  = winner ? 2'b10 : 2'b01;
                    last_d   = winner;
                    paddr_d  = winner ? m1_paddr : m0_paddr;
                    pwrite_d = winner ? m1_pwrite : m0_pwrite;
                    pwdata_d = winner ? m1_pwdata : m0_pwdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_psel    = active;
    assign s_penable = (state_q == ACCESS);
    assign s_pwrite  = active && pwrite_q;
    assign s_paddr   = active ? paddr_q : '0;
    assign s_pwdata  = active ? pwdata_q : '0;
    assign grant_o   = grant_q;

    // A timed-out transfer returns an error with zeroed read data instead of whatever the slave drives.
    assign m0_pready  = masterDone && grant_q[0];
    assign m0_pslverr = masterDone && grant_q[0] && (timeoutHit || s_pslverr);
    assign m0_prdata  = (masterDone && grant_q[0] && !timeoutHit) ? s_prdata : 32'h0;
    assign m1_pready  = masterDone && grant_q[1];
    assign m1_pslverr = masterDone && grant_q[1] && (timeoutHit || s_pslverr);
    assign m1_prdata  = (masterDone && grant_q[1] && !timeoutHit) ? s_prdata : 32'h0;

endmodule

// File: tb/tb_apb_timer_arbiter.sv
// Directed self-checking bench for apb_timer_arbiter: latency, round-robin order,
// wait states, timeout completion and reset in the middle of a transfer.
module tb_apb_timer_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic [11:0] m0_paddr;
    logic [31:0] m0_pwdata, m0_prdata;
    logic        m0_pready, m0_pslverr;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [11:0] m1_paddr;
    logic [31:0] m1_pwdata, m1_prdata;
    logic        m1_pready, m1_pslverr;
    logic        s_psel, s_penable, s_pwrite;
    logic [11:0] s_paddr;
    logic [31:0] s_pwdata, s_prdata;
    logic        s_pready, s_pslverr;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;
    int setupWrites = 0;

    apb_timer_arbiter #(.TIMEOUT(16), .AW(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic p0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                                 input logic p1, input logic w1, input logic [11:0] a1, input logic [31:0] d1);
        m0_psel = p0; m0_pwrite = w0; m0_paddr = a0; m0_pwdata = d0; m0_penable = 1'b0;
        m1_psel = p1; m1_pwrite = w1; m1_paddr = a1; m1_pwdata = d1; m1_penable = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        s_prdata = 32'h0; s_pready = 1'b0; s_pslverr = 1'b0;
        step(); step();
        checkOutput("rst_grant", 32'(grant_o), 32'h0);
        checkOutput("rst_spsel", 32'(s_psel), 32'h0);
        checkOutput("rst_m0ready", 32'(m0_pready), 32'h0);
        rst_i = 1'b0;

        // Single zero-wait read from master 0
        s_prdata = 32'hDEADBEEF; s_pready = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'h004, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        checkOutput("t1_T_spsel", 32'(s_psel), 32'h0);
        step();
        checkOutput("t1_setup_spsel", 32'(s_psel), 32'h1);
        checkOutput("t1_setup_spen", 32'(s_penable), 32'h0);
        checkOutput("t1_setup_grant", 32'(grant_o), 32'h1);
        checkOutput("t1_setup_paddr", 32'(s_paddr), 32'h004);
        checkOutput("t1_setup_m0rdy", 32'(m0_pready), 32'h0);
        m0_penable = 1'b1;
        step();
        checkOutput("t1_acc_spen", 32'(s_penable), 32'h1);
        checkOutput("t1_acc_m0rdy", 32'(m0_pready), 32'h1);
        checkOutput("t1_acc_m0data", m0_prdata, 32'hDEADBEEF);
        checkOutput("t1_acc_m1rdy", 32'(m1_pready), 32'h0);
        checkOutput("t1_acc_m1data", m1_prdata, 32'h0);
        checkOutput("t1_acc_m1err", 32'(m1_pslverr), 32'h0);
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        step();
        checkOutput("t1_idle_spsel", 32'(s_psel), 32'h0);
        checkOutput("t1_idle_grant", 32'(grant_o), 32'h0);
        checkOutput("t1_idle_paddr", 32'(s_paddr), 32'h0);

        // Simultaneous writes right after reset: master 0 first, master 1 three cycles later
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        s_prdata = 32'h0;
        applyStimulus(1'b1, 1'b1, 12'h010, 32'h1, 1'b1, 1'b1, 12'h014, 32'h2);
        step();
        checkOutput("t2_g0", 32'(grant_o), 32'h1);
        checkOutput("t2_addr0", 32'(s_paddr), 32'h010);
        checkOutput("t2_wdata0", s_pwdata, 32'h1);
        checkOutput("t2_write0", 32'(s_pwrite), 32'h1);
        step();
        checkOutput("t2_m0rdy", 32'(m0_pready), 32'h1);
        checkOutput("t2_m1wait", 32'(m1_pready), 32'h0);
        m0_psel = 1'b0;
        step();
        checkOutput("t2_bubble", 32'(s_psel), 32'h0);
        step();
        checkOutput("t2_g1", 32'(grant_o), 32'h2);
        checkOutput("t2_addr1", 32'(s_paddr), 32'h014);
        checkOutput("t2_wdata1", s_pwdata, 32'h2);
        checkOutput("t2_m1early", 32'(m1_pready), 32'h0);
        step();
        checkOutput("t2_m1rdy", 32'(m1_pready), 32'h1);
        checkOutput("t2_m0quiet", 32'(m0_pready), 32'h0);
        m1_psel = 1'b0;
        step();

        // Both masters requesting continuously for six transfers
        applyStimulus(1'b1, 1'b1, 12'h050, 32'h5, 1'b1, 1'b1, 12'h054, 32'h6);
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_psel && !s_penable && s_pwrite) setupWrites++;
            checkOutput($sformatf("t3_grant%0d", k), 32'(grant_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            if (s_psel && !s_penable && s_pwrite) setupWrites++;
            checkOutput($sformatf("t3_rdy%0d", k), 32'({m1_pready, m0_pready}), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            if (s_psel && !s_penable && s_pwrite) setupWrites++;
        end
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        checkOutput("t3_setupWrites", 32'(setupWrites), 32'd6);
        step();

        // Three slave wait states then an error response
        s_pready = 1'b0;
        applyStimulus(1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        step();
        step();
        checkOutput("t4_wait1", 32'(m0_pready), 32'h0);
        step();
        step();
        checkOutput("t4_wait3", 32'(m0_pready), 32'h0);
        step();
        s_pready = 1'b1; s_pslverr = 1'b1; s_prdata = 32'h12345678;
        #1;
        checkOutput("t4_rdy", 32'(m0_pready), 32'h1);
        checkOutput("t4_err", 32'(m0_pslverr), 32'h1);
        checkOutput("t4_data", m0_prdata, 32'h12345678);
        m0_psel = 1'b0;
        step();
        s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = 32'hCAFEF00D;

        // Slave never ready: forced error completion on the sixteenth access cycle
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0);
        step();
        step();
        repeat (14) step();
        checkOutput("t5_before", 32'(m1_pready), 32'h0);
        step();
        checkOutput("t5_rdy", 32'(m1_pready), 32'h1);
        checkOutput("t5_err", 32'(m1_pslverr), 32'h1);
        checkOutput("t5_data", m1_prdata, 32'h0);
        checkOutput("t5_grant", 32'(grant_o), 32'h2);
        m1_psel = 1'b0;
        step();
        checkOutput("t5_idle_spsel", 32'(s_psel), 32'h0);
        checkOutput("t5_idle_grant", 32'(grant_o), 32'h0);
        s_pready = 1'b1;
        m1_psel = 1'b1;
        step();
        step();
        checkOutput("t5_retry_rdy", 32'(m1_pready), 32'h1);
        checkOutput("t5_retry_err", 32'(m1_pslverr), 32'h0);
        checkOutput("t5_retry_data", m1_prdata, 32'hCAFEF00D);
        m1_psel = 1'b0;
        step();

        // Reset asserted in the access phase of a master 1 transfer
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h040, 32'h7);
        step();
        checkOutput("t6_setup_grant", 32'(grant_o), 32'h2);
        step();
        rst_i = 1'b1;
        m0_psel = 1'b1; m0_pwrite = 1'b1; m0_paddr = 12'h044; m0_pwdata = 32'h8;
        #1;
        checkOutput("t6_rst_m1rdy", 32'(m1_pready), 32'h0);
        step();
        checkOutput("t6_after_spsel", 32'(s_psel), 32'h0);
        checkOutput("t6_after_grant", 32'(grant_o), 32'h0);
        checkOutput("t6_after_rdy", 32'({m1_pready, m0_pready}), 32'h0);
        checkOutput("t6_after_paddr", 32'(s_paddr), 32'h0);
        rst_i = 1'b0;
        step();
        checkOutput("t6_m0_first", 32'(grant_o), 32'h1);
        checkOutput("t6_m0_addr", 32'(s_paddr), 32'h044);
        step();
        checkOutput("t6_m0_rdy", 32'(m0_pready), 32'h1);
        m0_psel = 1'b0;
        step();
        step();
        checkOutput("t6_m1_grant", 32'(grant_o), 32'h2);
        checkOutput("t6_m1_addr", 32'(s_paddr), 32'h040);
        step();
        checkOutput("t6_m1_rdy", 32'(m1_pready), 32'h1);
        m1_psel = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
